// File: rtl/aes_encipher_seq_pkg.sv
// ----------------------------------------------------------------------------
// aes_encipher_seq_pkg
// Shared AES constants: key-length selectors, round counts, FSM state type,
// the forward S-box table and the GF(2^8) helpers (xtime / gmul, poly 0x11B).
// ----------------------------------------------------------------------------
package aes_encipher_seq_pkg;

    localparam logic       AES_128_BIT_KEY    = 1'b0;
    localparam logic       AES_256_BIT_KEY    = 1'b1;
    localparam logic [3:0] AES_128_NUM_ROUNDS = 4'd10;
    localparam logic [3:0] AES_256_NUM_ROUNDS = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_MAIN  = 2'b01,
        ST_FINAL = 2'b10
    } enc_state_t;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bit offset (255-b)*8, and 255-b == ~b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// ----------------------------------------------------------------------------
// aes_round_comb
// One combinational AES round: SubBytes, ShiftRows, MixColumns (bypassed on
// the final round) and AddRoundKey.
//   i_state     128  current state, byte 0 in bits [127:120], column-major
//   i_round_key 128  round key to add
//   i_final     1    1 = last round, skip MixColumns
//   o_state     128  next state
// ----------------------------------------------------------------------------
module aes_round_comb
    import aes_encipher_seq_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_round_key,
    input  logic         i_final,
    output logic [127:0] o_state
);

    logic [15:0][7:0] w_sub;
    logic [15:0][7:0] w_shift;
    logic [15:0][7:0] w_mix;

    // Byte index r+4c is row r, column c.
    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign w_sub[i] = sbox(i_state[127-8*i -: 8]);
    end

    // Row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_shift[r+4*c] = w_sub[r+4*((c+r)%4)];
        end

        assign w_mix[4*c+0] = xtime(w_shift[4*c+0]) ^ gmul(w_shift[4*c+1], 8'h03)
                            ^ w_shift[4*c+2] ^ w_shift[4*c+3];
        assign w_mix[4*c+1] = w_shift[4*c+0] ^ xtime(w_shift[4*c+1])
                            ^ gmul(w_shift[4*c+2], 8'h03) ^ w_shift[4*c+3];
        assign w_mix[4*c+2] = w_shift[4*c+0] ^ w_shift[4*c+1]
                            ^ xtime(w_shift[4*c+2]) ^ gmul(w_shift[4*c+3], 8'h03);
        assign w_mix[4*c+3] = gmul(w_shift[4*c+0], 8'h03) ^ w_shift[4*c+1]
                            ^ w_shift[4*c+2] ^ xtime(w_shift[4*c+3]);
    end

    for (genvar i = 0; i < 16; i++) begin : g_ark
        assign o_state[127-8*i -: 8] = (i_final ? w_shift[i] : w_mix[i])
                                     ^ i_round_key[127-8*i -: 8];
    end

endmodule

// File: rtl/aes_encipher_seq.sv
// ----------------------------------------------------------------------------
// aes_encipher_seq
// Iterative AES-128/256 encipher, one round per clock. Round keys are read
// from an external key-schedule memory addressed by 'round'.
//   clk, rst_n  clock, async active-low reset
//   next        start request (accepted only in IDLE with key_ready)
//   keylen      0 = AES-128, 1 = AES-256 (latched at start)
//   key_ready   key schedule complete
//   block       plaintext (sampled at start only)
//   round_key   key for the index on 'round', same cycle
//   round       round index to key memory
//   new_block   running state / ciphertext
//   ready       idle and new_block holds last result
// ----------------------------------------------------------------------------
module aes_encipher_seq
    import aes_encipher_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         next,
    input  logic         keylen,
    input  logic         key_ready,
    input  logic [127:0] block,
    input  logic [127:0] round_key,
    output logic [3:0]   round,
    output logic [127:0] new_block,
    output logic         ready
);

    enc_state_t   r_state;
    logic [3:0]   r_round;
    logic         r_keylen;
    logic [127:0] r_block;
    logic         r_ready;

    enc_state_t   w_state_nxt;
    logic [3:0]   w_round_nxt;
    logic         w_keylen_nxt;
    logic [127:0] w_block_nxt;
    logic         w_ready_nxt;
    logic         w_final;
    logic [3:0]   w_last_main;
    logic [127:0] w_rnd_out;

    // Last MAIN round is Nr-1; FINAL handles round Nr.
    assign w_last_main = (r_keylen == AES_256_BIT_KEY) ? (AES_256_NUM_ROUNDS - 4'd1)
                                                       : (AES_128_NUM_ROUNDS - 4'd1);
    assign w_final     = (r_state == ST_FINAL);

    aes_round_comb u_round (
        .i_state     (r_block),
        .i_round_key (round_key),
        .i_final     (w_final),
        .o_state     (w_rnd_out)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_round_nxt  = r_round;
        w_keylen_nxt = r_keylen;
        w_block_nxt  = r_block;
        w_ready_nxt  = r_ready;
        case (r_state)
            ST_IDLE: begin
                if (next && key_ready) begin
                    // round is 0 here, so round_key is the whitening key
                    w_keylen_nxt = keylen;
                    w_block_nxt  = block ^ round_key;
                    w_round_nxt  = 4'd1;
                    w_ready_nxt  = 1'b0;
                    w_state_nxt  = ST_MAIN;
                end
            end
            ST_MAIN: begin
                w_block_nxt = w_rnd_out;
                w_round_nxt = r_round + 4'd1;
                if (r_round == w_last_main) w_state_nxt = ST_FINAL;
            end
            ST_FINAL: begin
                w_block_nxt = w_rnd_out;
                w_ready_nxt = 1'b1;
                w_round_nxt = 4'd0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_round_nxt = 4'd0;
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_round  <= 4'd0;
            r_keylen <= AES_128_BIT_KEY;
            r_block  <= 128'h0;
            r_ready  <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_round  <= w_round_nxt;
            r_keylen <= w_keylen_nxt;
            r_block  <= w_block_nxt;
            r_ready  <= w_ready_nxt;
        end
    end

    assign round     = r_round;
    assign new_block = r_block;
    assign ready     = r_ready;

endmodule

// File: tb/tb_aes_encipher_seq.sv
// ----------------------------------------------------------------------------
// tb_aes_encipher_seq
// Directed FIPS-197 vectors against aes_encipher_seq. The bench expands the
// key into a round-key table and serves round_key from it by 'round'.
// ----------------------------------------------------------------------------
module tb_aes_encipher_seq;
    import aes_encipher_seq_pkg::*;

    localparam logic [255:0] KEY128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT      = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] INIT128 = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] CT128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256   = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         next;
    logic         keylen;
    logic         key_ready;
    logic [127:0] block;
    logic [127:0] round_key;
    logic [3:0]   round;
    logic [127:0] new_block;
    logic         ready;

    logic [127:0] rk [16];
    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign round_key = rk[round];

    aes_encipher_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .next      (next),
        .keylen    (keylen),
        .key_ready (key_ready),
        .block     (block),
        .round_key (round_key),
        .round     (round),
        .new_block (new_block),
        .ready     (ready)
    );

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Key schedule memory contents (stimulus, not a model of the DUT).
    task automatic build_keys(input logic [255:0] key, input logic kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nk, nr;
        nk   = kl ? 8 : 4;
        nr   = kl ? 14 : 10;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = t ^ w[i-nk];
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk[r] = 128'h0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; next = 1'b0; keylen = 1'b0; key_ready = 1'b0; block = 128'h0;
        build_keys(KEY128, 1'b0);
        repeat (2) @(negedge clk);
        n_chk++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else n_pass++;
        n_chk++; if (round !== 4'd0) $display("FAIL reset_round: got %0d expected 0", round); else n_pass++;
        n_chk++; if (new_block !== 128'h0) $display("FAIL reset_block: got %h expected 0", new_block); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aes128();
        build_keys(KEY128, 1'b0);
        block = PT; keylen = 1'b0; key_ready = 1'b1; next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        n_chk++; if (new_block !== INIT128) $display("FAIL a128_init: got %h expected %h", new_block, INIT128); else n_pass++;
        n_chk++; if (round !== 4'd1) $display("FAIL a128_round1: got %0d expected 1", round); else n_pass++;
        n_chk++; if (ready !== 1'b0) $display("FAIL a128_busy: got %b expected 0", ready); else n_pass++;
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            n_chk++;
            if (round !== 4'(k) || ready !== 1'b0)
                $display("FAIL a128_seq: got round %0d ready %b expected round %0d ready 0", round, ready, k);
            else n_pass++;
        end
        @(negedge clk);
        n_chk++; if (ready !== 1'b1) $display("FAIL a128_ready: got %b expected 1", ready); else n_pass++;
        n_chk++; if (round !== 4'd0) $display("FAIL a128_round0: got %0d expected 0", round); else n_pass++;
        n_chk++; if (new_block !== CT128) $display("FAIL a128_ct: got %h expected %h", new_block, CT128); else n_pass++;
        block = 128'hdeadbeef; keylen = 1'b1;
        @(negedge clk);
        n_chk++; if (new_block !== CT128 || ready !== 1'b1)
            $display("FAIL a128_hold: got %h ready %b expected %h ready 1", new_block, ready, CT128); else n_pass++;
    endtask

    task automatic test_aes256();
        build_keys(KEY256, 1'b1);
        block = PT; keylen = 1'b1; key_ready = 1'b1; next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        n_chk++; if (round !== 4'd1) $display("FAIL a256_round1: got %0d expected 1", round); else n_pass++;
        for (int k = 2; k <= 14; k++) begin
            @(negedge clk);
            n_chk++;
            if (round !== 4'(k) || ready !== 1'b0)
                $display("FAIL a256_seq: got round %0d ready %b expected round %0d ready 0", round, ready, k);
            else n_pass++;
        end
        @(negedge clk);
        n_chk++; if (ready !== 1'b1) $display("FAIL a256_ready: got %b expected 1", ready); else n_pass++;
        n_chk++; if (new_block !== CT256) $display("FAIL a256_ct: got %h expected %h", new_block, CT256); else n_pass++;
    endtask

    task automatic test_key_not_ready();
        build_keys(KEY128, 1'b0);
        block = PT; keylen = 1'b0; key_ready = 1'b0; next = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_chk++;
            if (ready !== 1'b1 || round !== 4'd0 || new_block !== CT256)
                $display("FAIL knr_idle: got ready %b round %0d block %h expected ready 1 round 0 block %h",
                         ready, round, new_block, CT256);
            else n_pass++;
        end
        key_ready = 1'b1;
        @(negedge clk);
        next = 1'b0;
        n_chk++; if (round !== 4'd1 || new_block !== INIT128)
            $display("FAIL knr_accept: got round %0d block %h expected round 1 block %h", round, new_block, INIT128);
        else n_pass++;
        key_ready = 1'b0;  // dropping it mid-run must not abort
        repeat (9) @(negedge clk);
        @(negedge clk);
        n_chk++; if (ready !== 1'b1 || new_block !== CT128)
            $display("FAIL knr_ct: got ready %b block %h expected ready 1 block %h", ready, new_block, CT128);
        else n_pass++;
        key_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        build_keys(KEY128, 1'b0);
        block = PT; keylen = 1'b0; key_ready = 1'b1; next = 1'b1;
        @(negedge clk);
        n_chk++; if (round !== 4'd1) $display("FAIL b2b_accept0: got %0d expected 1", round); else n_pass++;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 5) begin
                keylen = 1'b1;
                block  = {$urandom, $urandom, $urandom, $urandom};
            end else if (k == 6) begin
                keylen = 1'b0;
                block  = PT;
            end
        end
        @(negedge clk);
        n_chk++; if (ready !== 1'b1 || new_block !== CT128)
            $display("FAIL b2b_ct0: got ready %b block %h expected ready 1 block %h", ready, new_block, CT128);
        else n_pass++;
        n_chk++; if (round !== 4'd0) $display("FAIL b2b_final_ignore: got %0d expected 0", round); else n_pass++;
        @(negedge clk);
        n_chk++; if (round !== 4'd1 || ready !== 1'b0 || new_block !== INIT128)
            $display("FAIL b2b_accept1: got round %0d ready %b block %h expected round 1 ready 0 block %h",
                     round, ready, new_block, INIT128);
        else n_pass++;
        repeat (9) @(negedge clk);
        @(negedge clk);
        n_chk++; if (ready !== 1'b1 || new_block !== CT128)
            $display("FAIL b2b_ct1: got ready %b block %h expected ready 1 block %h", ready, new_block, CT128);
        else n_pass++;
        next = 1'b0;
        @(negedge clk);
        n_chk++; if (ready !== 1'b1 || round !== 4'd0)
            $display("FAIL b2b_idle: got ready %b round %0d expected ready 1 round 0", ready, round);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        build_keys(KEY128, 1'b0);
        block = PT; keylen = 1'b0; key_ready = 1'b1; next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        repeat (4) @(negedge clk);
        n_chk++; if (round !== 4'd5) $display("FAIL rmid_round5: got %0d expected 5", round); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++; if (ready !== 1'b1 || round !== 4'd0 || new_block !== 128'h0)
            $display("FAIL rmid_async: got ready %b round %0d block %h expected ready 1 round 0 block 0",
                     ready, round, new_block);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1; next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        n_chk++; if (round !== 4'd1 || new_block !== INIT128)
            $display("FAIL rmid_accept: got round %0d block %h expected round 1 block %h", round, new_block, INIT128);
        else n_pass++;
        repeat (9) @(negedge clk);
        @(negedge clk);
        n_chk++; if (ready !== 1'b1 || new_block !== CT128)
            $display("FAIL rmid_ct: got ready %b block %h expected ready 1 block %h", ready, new_block, CT128);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_aes256();
        test_key_not_ready();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
